qnet_st_trace: RTL and testbench

QNET_ST_TRACE -- requirements
Module: qnet_st_trace

---
 rtl/qnet_st_trace.sv | 117 +++++++++++
 tb/tb_qnet_st_trace.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/qnet_st_trace.sv
// qnet_st_trace: state-transition history recorder for a command FSM.
// Logs {next state, dwell time} on every transition into a shift-style
// history. An optional trigger freezes the history POST_TRIG transitions
// after the trigger code is entered.
module qnet_st_trace #(
  parameter int ST_W      = 6,
  parameter int DEPTH     = 8,
  parameter int TS_W      = 16,
  parameter int POST_TRIG = 2,
  parameter int FILL_CODE = 62
) (
  input  logic                     st_clk_i,
  input  logic                     st_rst_i,
  input  logic [ST_W-1:0]          current_st_i,
  input  logic [ST_W-1:0]          next_st_i,
  input  logic                     clr_i,
  input  logic                     trig_en_i,
  input  logic [ST_W-1:0]          trig_code_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [ST_W+TS_W-1:0]     rd_dt_o,
  output logic [1:0]               trc_st_o,
  output logic [15:0]              trans_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int ENT_W = ST_W + TS_W;
  localparam int PT_W  = IDX_W;  // POST_TRIG <= DEPTH-1 always fits
  localparam logic [ENT_W-1:0] FILL_ENT = {ST_W'(FILL_CODE), {TS_W{1'b0}}};
  localparam logic [TS_W-1:0]  DW_MAX   = '1;

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    TRIGGERED = 2'd1,
    FROZEN    = 2'd2
  } trc_e;

  trc_e                        state_q, state_d;
  logic [PT_W-1:0]             pt_q, pt_d;
  logic [DEPTH-1:0][ENT_W-1:0] ent_q, ent_d;
  logic [TS_W-1:0]             dwell_q, dwell_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [ENT_W-1:0]            rd_q, rd_d;
  logic                        trans;

  assign trans       = (current_st_i != next_st_i);
  assign trc_st_o    = state_q;
  assign trans_cnt_o = cnt_q;
  assign rd_dt_o     = rd_q;

  // Next-state: clear wins over logging; FROZEN holds everything.
  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    ent_d   = ent_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      for (int k = 0; k < DEPTH; k++) ent_d[k] = FILL_ENT;
      dwell_d = '0;
      cnt_d   = '0;
      state_d = ARMED;
      pt_d    = '0;
    end else if (state_q != FROZEN) begin
      if (trans) begin
        ent_d[0] = {next_st_i, dwell_q};
        for (int k = 1; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
        dwell_d = TS_W'(1);
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        case (state_q)
          ARMED: begin
            if (trig_en_i && (next_st_i == trig_code_i)) begin
              if (POST_TRIG == 0) begin
                state_d = FROZEN;
              end else begin
                state_d = TRIGGERED;
                pt_d    = PT_W'(POST_TRIG);
              end
            end
          end
          TRIGGERED: begin
            pt_d = pt_q - PT_W'(1);
            if (pt_q == PT_W'(1)) state_d = FROZEN;
          end
          default: ;
        endcase
      end else if (dwell_q != DW_MAX) begin
        dwell_d = dwell_q + TS_W'(1);
      end
    end
  end

  // Read port samples pre-update content; out-of-range index reads zero.
  always_comb begin
    rd_d = '0;
    if ({1'b0, rd_idx_i} < (IDX_W+1)'(DEPTH)) rd_d = ent_q[rd_idx_i];
  end

  // State registers; reset leaves entry 0 zero and the rest at fill.
  always_ff @(posedge st_clk_i or posedge st_rst_i) begin
    if (st_rst_i) begin
      state_q <= ARMED;
      pt_q    <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= (k == 0) ? '0 : FILL_ENT;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ent_q   <= ent_d;
    end
  end

endmodule

// File: tb/tb_qnet_st_trace.sv
// Bench for qnet_st_trace: a default instance (A) and a DEPTH=6, TS_W=4,
// POST_TRIG=0 instance (B) share stimulus. Reads go through a scoreboard
// queue: expected entry pushed when rd_idx is driven, popped after the edge.
module tb_qnet_st_trace;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  cur, nxt, tcode;
  logic        clr, ten_a, ten_b;
  logic [2:0]  ridx;
  logic [21:0] rd_a;
  logic [9:0]  rd_b;
  logic [1:0]  st_a, st_b;
  logic [15:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    bit         b;
    logic [21:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    int idx;
    int code;
    int dwell;
  } vec_t;

  always #5 clk = ~clk;

  qnet_st_trace dut_a (
    .st_clk_i(clk), .st_rst_i(rst), .current_st_i(cur), .next_st_i(nxt),
    .clr_i(clr), .trig_en_i(ten_a), .trig_code_i(tcode), .rd_idx_i(ridx),
    .rd_dt_o(rd_a), .trc_st_o(st_a), .trans_cnt_o(cnt_a)
  );

  qnet_st_trace #(.DEPTH(6), .TS_W(4), .POST_TRIG(0)) dut_b (
    .st_clk_i(clk), .st_rst_i(rst), .current_st_i(cur), .next_st_i(nxt),
    .clr_i(clr), .trig_en_i(ten_b), .trig_code_i(tcode), .rd_idx_i(ridx),
    .rd_dt_o(rd_b), .trc_st_o(st_b), .trans_cnt_o(cnt_b)
  );

  function automatic logic [21:0] ea(int c, int d);
    return {6'(c), 16'(d)};
  endfunction

  function automatic logic [21:0] eb(int c, int d);
    return {12'd0, 6'(c), 4'(d)};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a read index, queue the expectation, compare after the edge.
  task automatic rd(string name, bit b, int idx, logic [21:0] e);
    sb_t s;
    ridx = 3'(idx);
    sbq.push_back('{name, b, e});
    tick();
    s = sbq.pop_front();
    chk(s.name, s.b ? {54'd0, rd_b} : {42'd0, rd_a}, {42'd0, s.exp});
  endtask

  initial begin
    vec_t v1[4];
    vec_t v2[4];
    int   codes[4];
    int   sts[4];
    int   prev;

    v1[0] = '{0, 2, 10}; v1[1] = '{1, 0, 0};  v1[2] = '{2, 62, 0}; v1[3] = '{7, 62, 0};
    v2[0] = '{0, 8, 1};  v2[1] = '{1, 7, 1};  v2[2] = '{2, 5, 0};  v2[3] = '{3, 62, 0};
    codes = '{5, 7, 8, 9};
    sts   = '{1, 1, 2, 2};

    cur = '0; nxt = '0; tcode = '0; clr = 0; ten_a = 0; ten_b = 0; ridx = '0;
    tick(); tick();
    chk("rst_st", 64'(st_a), 64'(0));
    chk("rst_cnt", 64'(cnt_a), 64'(0));
    chk("rst_rd", 64'(rd_a), 64'(0));

    // Release reset; the release edge plus nine hold cycles give dwell 10.
    rst = 0; cur = 6'd1; nxt = 6'd1;
    repeat (10) tick();
    nxt = 6'd2;
    tick();
    cur = 6'd2;
    chk("first_cnt", 64'(cnt_a), 64'(1));
    for (int i = 0; i < 4; i++)
      rd($sformatf("first_e%0d", v1[i].idx), 0, v1[i].idx, ea(v1[i].code, v1[i].dwell));

    // Back-to-back transitions; reads on those edges see pre-shift content.
    cur = 6'd1; nxt = 6'd3;
    rd("preshift0", 0, 0, ea(2, 10));
    cur = 6'd3; nxt = 6'd4;
    rd("preshift1", 0, 0, ea(3, 5));
    cur = 6'd4;
    rd("b2b_e0", 0, 0, ea(4, 1));
    rd("b2b_e1", 0, 1, ea(3, 5));
    rd("b2b_e2", 0, 2, ea(2, 10));
    chk("b2b_cnt", 64'(cnt_a), 64'(3));

    // Trigger with two post-trigger transitions.
    clr = 1; tick(); clr = 0;
    chk("clr_cnt", 64'(cnt_a), 64'(0));
    ten_a = 1; tcode = 6'd5; prev = 4;
    for (int i = 0; i < 4; i++) begin
      cur = 6'(prev); nxt = 6'(codes[i]);
      tick();
      chk($sformatf("trig_st%0d", i), 64'(st_a), 64'(sts[i]));
      prev = codes[i];
    end
    cur = 6'd9; nxt = 6'd9; ten_a = 0;
    chk("trig_cnt", 64'(cnt_a), 64'(3));
    for (int i = 0; i < 4; i++)
      rd($sformatf("trig_e%0d", v2[i].idx), 0, v2[i].idx, ea(v2[i].code, v2[i].dwell));

    // Clear while frozen, with a same-cycle transition that must be dropped.
    cur = 6'd9; nxt = 6'd10; clr = 1;
    tick();
    clr = 0; cur = 6'd10;
    chk("frzclr_st", 64'(st_a), 64'(0));
    chk("frzclr_cnt", 64'(cnt_a), 64'(0));
    rd("frzclr_e0", 0, 0, ea(62, 0));
    rd("frzclr_e7", 0, 7, ea(62, 0));

    // 40-cycle dwell: saturates in the 4-bit instance.
    clr = 1; tick(); clr = 0;
    repeat (40) tick();
    nxt = 6'd11;
    tick();
    cur = 6'd11;
    rd("dwell40_a", 0, 0, ea(11, 40));
    rd("dwell_sat_b", 1, 0, eb(11, 15));
    rd("oob_b", 1, 6, eb(0, 0));
    rd("last_b", 1, 5, eb(62, 0));

    // POST_TRIG=0 goes straight to FROZEN.
    ten_b = 1; tcode = 6'd12; nxt = 6'd12;
    tick();
    cur = 6'd12; ten_b = 0;
    chk("pt0_st_b", 64'(st_b), 64'(2));
    chk("pt0_st_a", 64'(st_a), 64'(0));

    // Asynchronous reset in the middle of a capture.
    ten_a = 1; tcode = 6'd13; nxt = 6'd13;
    tick();
    cur = 6'd13;
    chk("mid_trig_st", 64'(st_a), 64'(1));
    #3 rst = 1;
    #1;
    chk("arst_st", 64'(st_a), 64'(0));
    chk("arst_cnt", 64'(cnt_a), 64'(0));
    chk("arst_rd", 64'(rd_a), 64'(0));
    chk("arst_st_b", 64'(st_b), 64'(0));
    #1 rst = 0; ten_a = 0;
    rd("arst_e0", 0, 0, ea(0, 0));
    rd("arst_e1", 0, 1, ea(62, 0));
    chk("arst_st_after", 64'(st_a), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
